// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
// Module      : memory_cycle
// Description : Memory stage of a 5-stage RV32I pipeline. Holds the
//               word-addressed data memory, which is read combinationally and
//               written on the rising clock edge. Registers the M-to-W
//               pipeline fields for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_cycle #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
);

    // Data memory. Contents start at zero and are deliberately not cleared
    // by reset, so stored data survives a pipeline reset.
    logic [31:0] r_mem [MEM_DEPTH] = '{default: 32'h0000_0000};

    // Word index: byte-offset bits are dropped and everything above the
    // index is ignored, so byte addresses wrap modulo MEM_DEPTH*4.
    logic [ADDR_BITS-1:0] w_word_index;
    logic [31:0]          w_read_data;

    assign w_word_index = ALU_ResultM[ADDR_BITS+1:2];

    // Asynchronous read; on a same-edge store/load the pipeline register
    // captures this pre-write word, the new word shows up one cycle later.
    assign w_read_data = r_mem[w_word_index];

    // Full-word store, suppressed while reset is held low.
    always_ff @(posedge clk) begin
        if (rst && MemWriteM) begin
            r_mem[w_word_index] <= WriteDataM;
        end
    end

    // M-to-W pipeline register, cleared asynchronously by active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'h0000_0000;
            ALU_ResultW <= 32'h0000_0000;
            ReadDataW   <= 32'h0000_0000;
        end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= w_read_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_cycle
// Description : Scoreboard bench for memory_cycle. A driver issues directed
//               vectors and queues the hand-computed W-stage response; a
//               monitor compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;

    memory_cycle #(
        .MEM_DEPTH (1024),
        .ADDR_BITS (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW)
    );

    typedef struct {
        int          tag;
        string       name;
        logic [102:0] exp_bits;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   edge_cnt = 0;

    // Packed view of all six W outputs: rw, rs, rd, pc, alu, rdata.
    function automatic logic [102:0] outs();
        return {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW};
    endfunction

    task automatic chk(input string name, input logic [102:0] act, input logic [102:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: after each rising edge, compare every response due at it.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                if (e.tag < edge_cnt) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL %s: response missed, tag %0d edge %0d", e.name, e.tag, edge_cnt);
                end else begin
                    chk(e.name, outs(), e.exp_bits);
                end
            end
        end
    end

    // Drive one vector at the falling edge and queue its expected W response.
    task automatic apply(input string name, input logic rw, input logic mw, input logic rs,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = alu;
        e.tag      = edge_cnt + 1;
        e.name     = name;
        e.exp_bits = {rw, rs, rd, pc, alu, exp_rdata};
        sb.push_back(e);
    endtask

    initial begin
        // Reset held with a store request that must be ignored.
        rst         = 1'b0;
        RegWriteM   = 1'b1;
        MemWriteM   = 1'b1;
        ResultSrcM  = 1'b1;
        RD_M        = 5'd7;
        PCPlus4M    = 32'h0000_0040;
        WriteDataM  = 32'hA5A5_A5A5;
        ALU_ResultM = 32'h0000_0004;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 103'd0);

        // Asynchronous release: outputs stay zero until the next edge.
        @(negedge clk);
        MemWriteM = 1'b0;
        rst       = 1'b1;
        #1;
        chk("release_hold", outs(), 103'd0);

        apply("load_after_reset", 1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0100, 32'h0, 32'h0000_0004, 32'h0000_0000);

        // Store then load.
        apply("store_4",          1'b1, 1'b1, 1'b0, 5'd1,  32'h0000_0104, 32'hA5A5_A5A5, 32'h0000_0004, 32'h0000_0000);
        apply("load_4",           1'b1, 1'b0, 1'b1, 5'd1,  32'h0000_0108, 32'h0, 32'h0000_0004, 32'hA5A5_A5A5);

        // Pass-through of the non-memory fields.
        apply("pass_through",     1'b1, 1'b0, 1'b0, 5'd31, 32'h0000_0010, 32'h0, 32'h1234_5678, 32'h0000_0000);

        // Same-edge store/load returns the old word.
        apply("store_8_first",    1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0200, 32'h1111_1111, 32'h0000_0008, 32'h0000_0000);
        apply("store_8_old_read", 1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0204, 32'h2222_2222, 32'h0000_0008, 32'h1111_1111);
        apply("load_8_new",       1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0208, 32'h0, 32'h0000_0008, 32'h2222_2222);

        // Address aliasing: byte offset and upper bits ignored.
        apply("store_c",          1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_000C, 32'h0000_0000);
        apply("load_f",           1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_0304, 32'h0, 32'h0000_000F, 32'hDEAD_BEEF);
        apply("load_100c",        1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_0308, 32'h0, 32'h0000_100C, 32'hDEAD_BEEF);

        // Top word of memory and wrap from the top of the address space.
        apply("store_ffc",        1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0400, 32'hCAFE_F00D, 32'h0000_0FFC, 32'h0000_0000);
        apply("load_fffffffc",    1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0404, 32'h0, 32'hFFFF_FFFC, 32'hCAFE_F00D);

        // Mid-operation reset with a pending store to 0x20.
        @(negedge clk);
        RegWriteM   = 1'b1;
        MemWriteM   = 1'b1;
        ResultSrcM  = 1'b0;
        RD_M        = 5'd5;
        PCPlus4M    = 32'h0000_0500;
        WriteDataM  = 32'h0000_0055;
        ALU_ResultM = 32'h0000_0020;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_reset_async", outs(), 103'd0);
        @(posedge clk);
        #1;
        chk("mid_reset_edge", outs(), 103'd0);
        @(negedge clk);
        MemWriteM = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mid_release_hold", outs(), 103'd0);

        apply("load_20",          1'b1, 1'b0, 1'b1, 5'd6,  32'h0000_0600, 32'h0, 32'h0000_0020, 32'h0000_0000);
        apply("load_4_kept",      1'b0, 1'b0, 1'b1, 5'd6,  32'h0000_0604, 32'h0, 32'h0000_0004, 32'hA5A5_A5A5);

        // Drain the scoreboard within a bounded number of edges.
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory (M) stage of the 5-stage RV32I pipeline, between execute_cycle and writeback_cycle.
- Holds the word-addressed data memory:
  - stores on MemWriteM;
  - reads combinationally at ALU_ResultM.
- Registers the M-to-W pipeline fields (control, destination register, PC+4, ALU result, load data) for the writeback stage.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in data memory (power of two).
- ADDR_BITS, 10, log2(MEM_DEPTH); word index width.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- RegWriteM  input  1  register-file write enable of the M-stage instruction.
- MemWriteM  input  1  data-memory store enable.
- ResultSrcM  input  1  writeback mux select (0 = ALU result, 1 = load data).
- RD_M  input  5  destination register index.
- PCPlus4M  input  32  PC+4 of the M-stage instruction.
- WriteDataM  input  32  store data.
- ALU_ResultM  input  32  effective byte address / ALU result.
- RegWriteW  output  1  registered RegWriteM.
- ResultSrcW  output  1  registered ResultSrcM.
- RD_W  output  5  registered RD_M.
- PCPlus4W  output  32  registered PCPlus4M.
- ALU_ResultW  output  32  registered ALU_ResultM.
- ReadDataW  output  32  registered memory read data.

Behaviour:
- Reset:
  - While rst=0, every output is 0 (RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW), asynchronously, regardless of clk.
  - Memory writes are inhibited while rst=0.
  - Memory contents are not cleared by reset.
  - All words are 0 at time zero (initialised array).
- Addressing:
  - Word index = ALU_ResultM[ADDR_BITS+1:2].
  - Bits [1:0] are ignored (word access only; no byte/half enables).
  - Upper bits above the index are ignored, so addresses wrap modulo MEM_DEPTH*4 bytes.
- Read:
  - Combinational, from the memory array at the current word index.
  - Loads occur irrespective of ResultSrcM or MemWriteM.
- Write:
  - On rising clk with rst=1 and MemWriteM=1, mem[index] <= WriteDataM (full 32 bits).
- Pipeline register:
  - On each rising clk with rst=1, all six W outputs capture their M inputs.
  - ReadDataW captures the combinational read value.
  - Latency from M inputs to W outputs is exactly 1 cycle; no stall or flush inputs.
- Simultaneous store and load, same edge and same address: ReadDataW gets the pre-write (old) word; the new word is visible to accesses in the following cycle.
- Reset deasserted asynchronously: outputs stay 0 until the next rising edge after rst rises.
- Reset asserted mid-store: the store on that edge is not performed; outputs go to 0 immediately.
- X on MemWriteM while rst=1 need not be tolerated; the bench drives known values.

Test Plan:
1. Reset:
   - Stimulus: hold rst=0 for 2 cycles with arbitrary inputs, including MemWriteM=1, ALU_ResultM=0x4, WriteDataM=0xA5A5A5A5.
   - Required: all outputs 0.
   - Required: after release, a load from 0x4 returns 0 (store was inhibited).
2. Store then load:
   - Stimulus: rst=1; cycle N: MemWriteM=1, RegWriteM=1, RD_M=1, ALU_ResultM=0x4, WriteDataM=0xA5A5A5A5.
   - Stimulus: cycle N+1: MemWriteM=0, ResultSrcM=1, same address.
   - Required: after edge N+1, ReadDataW=0xA5A5A5A5, ResultSrcW=1, RD_W=1, RegWriteW=1, ALU_ResultW=0x4.
3. Pass-through:
   - Stimulus: PCPlus4M=0x00000010, ALU_ResultM=0x12345678, RD_M=31, MemWriteM=0.
   - Required: one edge later, PCPlus4W=0x10, ALU_ResultW=0x12345678, RD_W=31.
4. Same-cycle write/read:
   - Stimulus: mem[0x8]=0x11111111; store 0x22222222 to 0x8.
   - Required: ReadDataW after that edge = 0x11111111.
   - Required: ReadDataW on the next edge (no store) = 0x22222222.
5. Address aliasing:
   - Stimulus: store 0xDEADBEEF to 0x0000000C; load from 0x0000000F and from 0x0000100C (MEM_DEPTH=1024).
   - Required: both return 0xDEADBEEF.
6. Mid-operation reset:
   - Stimulus: pull rst=0 between edges with valid inputs and MemWriteM=1 to 0x20 with data 0x55.
   - Required: outputs go 0 immediately, without waiting for an edge.
   - Required: a later load from 0x20 returns 0 (store inhibited).
